// File: rtl/debug_run_controller_if.sv
// UART-side handshake bundle of the debug run controller:
// received command bytes in, report bytes out with tx pacing.
interface debug_run_controller_if #(
  parameter int DATA_SIZE = 8
);
  logic [DATA_SIZE-1:0] i_rx_data;
  logic                 i_rx_done;
  logic                 i_tx_done;
  logic [DATA_SIZE-1:0] o_tx_data;
  logic                 o_tx_start;

  modport slave (
    input  i_rx_data,
    input  i_rx_done,
    input  i_tx_done,
    output o_tx_data,
    output o_tx_start
  );

  modport master (
    output i_rx_data,
    output i_rx_done,
    output i_tx_done,
    input  o_tx_data,
    input  o_tx_start
  );
endinterface

// File: rtl/debug_run_controller.sv
// Debug run controller: gates the pipeline enable (run / single-step)
// and reports PC and enabled-cycle count as little-endian UART bytes.
module debug_run_controller #(
  parameter int PC_SIZE   = 32,
  parameter int DATA_SIZE = 8,
  parameter int CNT_SIZE  = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  debug_run_controller_if.slave io_uart,
  input  logic [PC_SIZE-1:0] i_pc,
  input  logic               i_halt,
  output logic               o_enable,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_LOAD      = 3'd4,
    S_SEND      = 3'd5
  } state_t;

  localparam int BUF_SIZE  = PC_SIZE + CNT_SIZE;
  localparam int PC_BYTES  = PC_SIZE / DATA_SIZE;
  localparam int ALL_BYTES = BUF_SIZE / DATA_SIZE;

  localparam logic [3:0] LAST_PC  = 4'(PC_BYTES - 1);
  localparam logic [3:0] LAST_ALL = 4'(ALL_BYTES - 1);

  localparam logic [DATA_SIZE-1:0] CMD_C = DATA_SIZE'('h43);
  localparam logic [DATA_SIZE-1:0] CMD_S = DATA_SIZE'('h53);
  localparam logic [DATA_SIZE-1:0] CMD_N = DATA_SIZE'('h4E);
  localparam logic [DATA_SIZE-1:0] CMD_E = DATA_SIZE'('h45);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_SIZE-1:0]  r_cnt;
  logic [BUF_SIZE-1:0]  r_buf;
  logic [3:0]           r_idx;
  logic                 r_halt;
  logic [DATA_SIZE-1:0] r_tx_data;
  logic                 r_tx_start;

  logic w_is_c;
  logic w_is_s;
  logic w_is_n;
  logic w_is_e;
  logic w_byte_done;
  logic w_last;

  assign w_is_c = io_uart.i_rx_done && (io_uart.i_rx_data == CMD_C);
  assign w_is_s = io_uart.i_rx_done && (io_uart.i_rx_data == CMD_S);
  assign w_is_n = io_uart.i_rx_done && (io_uart.i_rx_data == CMD_N);
  assign w_is_e = io_uart.i_rx_done && (io_uart.i_rx_data == CMD_E);

  // A done pulse only counts once our own start pulse has dropped.
  assign w_byte_done = (r_state == S_SEND) && io_uart.i_tx_done
                       && !r_tx_start;
  assign w_last = (r_idx == (r_halt ? LAST_ALL : LAST_PC));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_is_c:  w_next = S_RUN;
          w_is_s:  w_next = S_STEP_WAIT;
          default: w_next = S_IDLE;
        endcase
      end
      S_RUN: if (i_halt) w_next = S_LOAD;
      S_STEP_WAIT: begin
        unique case (1'b1)
          w_is_n:  w_next = S_STEP_EXEC;
          w_is_e:  w_next = S_IDLE;
          default: w_next = S_STEP_WAIT;
        endcase
      end
      S_STEP_EXEC: w_next = S_LOAD;
      S_LOAD:      w_next = S_SEND;
      S_SEND: begin
        if (w_byte_done && w_last)
          w_next = r_halt ? S_IDLE : S_STEP_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt      <= '0;
      r_buf      <= '0;
      r_idx      <= '0;
      r_halt     <= 1'b0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_is_c || w_is_s) r_cnt <= '0;
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_SIZE'(1);
          if (i_halt) r_halt <= 1'b1;
        end
        S_STEP_EXEC: begin
          r_cnt  <= r_cnt + CNT_SIZE'(1);
          r_halt <= i_halt;
        end
        S_LOAD: begin
          r_buf      <= {r_cnt, i_pc};
          r_idx      <= '0;
          r_tx_data  <= i_pc[DATA_SIZE-1:0];
          r_tx_start <= 1'b1;
        end
        S_SEND: begin
          if (w_byte_done) begin
            if (w_last) begin
              r_halt <= 1'b0;
            end else begin
              r_idx      <= r_idx + 4'd1;
              r_buf      <= r_buf >> DATA_SIZE;
              r_tx_data  <= r_buf[2*DATA_SIZE-1:DATA_SIZE];
              r_tx_start <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_enable = (r_state == S_RUN) || (r_state == S_STEP_EXEC);
  assign o_state  = r_state;

  assign io_uart.o_tx_data  = r_tx_data;
  assign io_uart.o_tx_start = r_tx_start;

endmodule

// File: doc/debug_run_controller.md
Name: debug_run_controller

Overview:
- Drives the pipeline-wide enable into the program counter and the stage registers. Two run modes: continuous until HALT, or single-step.
- Commands arrive as UART bytes. Results leave as UART bytes: the PC, plus the cycle count when the program halts.
- Sits between the UART rx/tx pair and the IF stage; its o_enable is the PC's enable input.

Parameters:
PC_SIZE, 32, width of program counter value
DATA_SIZE, 8, UART byte width
CNT_SIZE, 32, width of enabled-cycle counter

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  DATA_SIZE  received command byte
i_rx_done  in  1  one-cycle pulse, i_rx_data valid
i_tx_done  in  1  one-cycle pulse, UART tx finished current byte
i_pc  in  PC_SIZE  current PC from IF stage
i_halt  in  1  HALT instruction retired (level)
o_enable  out  1  pipeline/PC enable
o_tx_data  out  DATA_SIZE  byte to transmit
o_tx_start  out  1  one-cycle pulse, start transmitting o_tx_data
o_state  out  3  current FSM state (debug visibility)

Behaviour:
- Reset (i_reset=0, takes effect immediately):
  - State IDLE (0); o_enable=0; o_tx_start=0; o_tx_data=0.
  - Cycle counter, send buffer, byte index and halt flag all cleared.
  - Applies mid-transmission too: any in-flight o_tx_start pulse is dropped.
- Commands: 0x43 'C' continuous, 0x53 'S' enter step, 0x4E 'N' next step, 0x45 'E' exit step. Any other byte is ignored. Bytes arriving in RUN, STEP_EXEC, LOAD or SEND are dropped.
- States and encodings:
  - IDLE=0. 'C' -> RUN; 'S' -> STEP_WAIT. Either command clears the cycle counter.
  - RUN=1. o_enable=1; counter +1 per cycle. If i_halt=1 at a clock edge: o_enable=0 from the next cycle, go to LOAD with halt flag=1.
  - STEP_WAIT=2. o_enable=0. 'N' -> STEP_EXEC; 'E' -> IDLE, no output.
  - STEP_EXEC=3. o_enable=1 for exactly one cycle; counter +1; i_halt sampled into the halt flag; then -> LOAD.
  - LOAD=4. o_enable=0. Captures i_pc (now stable) and the counter into the send buffer. Byte total = 8 if halt flag set, else 4. -> SEND.
  - SEND=5. Per byte: o_tx_data = next byte, o_tx_start pulsed for one cycle, then wait for i_tx_done. After the last byte's i_tx_done: halt flag set -> IDLE (flag cleared); otherwise -> STEP_WAIT.
- Latency:
  - i_rx_done for 'C' at edge N -> o_enable=1 in cycle N+1.
  - i_halt seen at edge M -> o_enable=0 in cycle M+1; LOAD in M+1; first o_tx_start in M+2.
- Byte order: little-endian, PC bytes first, then the counter. Halt report: PC[7:0], PC[15:8], PC[23:16], PC[31:24], CNT[7:0] .. CNT[31:24].
- Byte pacing:
  - o_tx_start is never reasserted before the matching i_tx_done.
  - The next o_tx_start follows i_tx_done by exactly one cycle.
  - i_tx_done outside SEND is ignored.
- Counter wraps modulo 2^CNT_SIZE and never saturates. The reported count equals the number of cycles o_enable was 1 since the last 'C'/'S'.
- In RUN the halt check runs every cycle, so i_halt already high on the first RUN cycle stops after one enabled cycle (count=1).
- In step mode, a step that retires HALT produces the 8-byte report and returns to IDLE.
- Simultaneous i_rx_done and i_halt in RUN: the halt wins and the byte is dropped.

Test Plan:
- Reset then 'C'; i_halt raised after 10 enabled cycles with i_pc=0x0000_0028 -> o_enable high exactly 10 cycles; 8 bytes sent: 28 00 00 00 0A 00 00 00; state back to IDLE.
- 'S', then 3x 'N' with i_pc=0x4, 0x8, 0xC after each step -> one-cycle o_enable per 'N'; three 4-byte reports: 04 00 00 00 / 08 00 00 00 / 0C 00 00 00; state STEP_WAIT.
- Step mode, i_halt high during the 2nd 'N', i_pc=0x10 -> report 10 00 00 00 02 00 00 00; state IDLE; a later 'N' is ignored.
- Hold i_tx_done low for 50 cycles after each o_tx_start -> exactly one o_tx_start per byte, each 1 cycle wide; the next start comes 1 cycle after i_tx_done.
- Bytes 0x41 and 0x4E in IDLE, and 'C' sent during SEND -> no state change and no enable.
- Assert i_reset=0 mid-SEND after byte 2 -> outputs zero immediately (async); no further o_tx_start; after release, 'C' restarts with count from 0.
